// File: rtl/sub44_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub44_pkg
// Brief    : Shared widths, default chunk size and FSM state encoding for the
//            44-bit multi-cycle subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sub44_pkg;

   localparam int OPA_W           = 44;   // minuend width
   localparam int OPB_W           = 43;   // subtrahend width (zero-extended)
   localparam int RES_W           = 45;   // {borrow, difference}
   localparam int CHUNK_W_DEFAULT = 11;   // bits processed per cycle

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sub44_state_t;

endpackage : sub44_pkg
`default_nettype wire

// File: rtl/chunk_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : chunk_subtractor
// Brief    : Combinational W-bit subtractor with borrow in/out. One instance
//            is time-multiplexed across all chunks of the 44-bit operands.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_subtractor #(
   parameter int W = 11
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         borrow_in,
   output logic [W-1:0] diff,
   output logic         borrow_out
);

   // One extra bit catches the borrow: a negative result wraps into bit W.
   logic [W:0] w_full;

   assign w_full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
   assign diff       = w_full[W-1:0];
   assign borrow_out = w_full[W];

endmodule : chunk_subtractor
`default_nettype wire

// File: rtl/custom_subtractor44_seq.sv
`default_nettype none
// ============================================================================
// Module   : custom_subtractor44_seq
// Brief    : Multi-cycle 44-bit subtractor, Diff = {1'b0,A} - {2'b0,B}.
//            Subtracts CHUNK_W bits per cycle with a registered borrow chain;
//            valid/ready handshakes on both operand and result sides.
//            Optional macro SUB44_ZERO_FLAG_EN adds the Zero output.
//            CHUNK_W must divide 44 (1, 2, 4, 11, 22, 44).
// Revision : 1.0 - initial release
// ============================================================================
module custom_subtractor44_seq
   import sub44_pkg::*;
#(
   parameter int CHUNK_W = CHUNK_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPA_W-1:0] A,
   input  logic [OPB_W-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] Diff
`ifdef SUB44_ZERO_FLAG_EN
   ,
   output logic             Zero
`endif
);

   localparam int N_CHUNKS = OPA_W / CHUNK_W;
   localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_CHUNKS - 1);

   sub44_state_t       r_state;
   sub44_state_t       w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [OPA_W-1:0]   r_a;        // minuend, shifted right one chunk per cycle
   logic [OPA_W-1:0]   r_b;        // zero-extended subtrahend, shifted likewise
   logic [OPA_W-1:0]   r_res;      // result, filled from the top chunk downwards
   logic               r_borrow;
   logic               w_accept;
   logic               w_out_fire;
   logic               w_busy;
   logic               w_last;
   logic [CHUNK_W-1:0] w_diff;
   logic               w_borrow_out;
   logic [OPA_W-1:0]   w_res_next;

   assign w_accept   = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_busy     = (r_state == BUSY);
   assign w_last     = (r_cnt == c_LAST);

   // Operand shifting means the active chunk is always the low slice, so the
   // single subtractor sees no wide operand mux.
   chunk_subtractor #(
      .W (CHUNK_W)
   ) u_chunk (
      .a          (r_a[CHUNK_W-1:0]),
      .b          (r_b[CHUNK_W-1:0]),
      .borrow_in  (r_borrow),
      .diff       (w_diff),
      .borrow_out (w_borrow_out)
   );

   // Result slot register: after N_CHUNKS shifts chunk 0 lands in the low bits.
   generate
      if (N_CHUNKS == 1) begin : g_single
         assign w_res_next = w_diff;
      end else begin : g_multi
         assign w_res_next = {w_diff, r_res[OPA_W-1:CHUNK_W]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept)   w_next_state = BUSY;
         BUSY:    if (w_last)     w_next_state = DONE;
         DONE:    if (w_out_fire) w_next_state = IDLE;
         default:                 w_next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Datapath: capture on accept, one chunk per BUSY cycle, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_a      <= A;
         r_b      <= {1'b0, B};
         r_borrow <= 1'b0;
      end else if (w_busy) begin
         r_cnt    <= r_cnt + 1'b1;
         r_a      <= r_a >> CHUNK_W;
         r_b      <= r_b >> CHUNK_W;
         r_res    <= w_res_next;
         r_borrow <= w_borrow_out;
      end
   end

   assign Diff = {r_borrow, r_res};

`ifdef SUB44_ZERO_FLAG_EN
   logic r_nonzero;

   // Sticky record of any nonzero chunk result within the current operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_nonzero <= 1'b0;
      else if (w_accept) r_nonzero <= 1'b0;
      else if (w_busy)   r_nonzero <= r_nonzero | (|w_diff);
   end

   assign Zero = ~r_nonzero & ~r_borrow;
`endif

endmodule : custom_subtractor44_seq
`default_nettype wire

// File: tb/tb_custom_subtractor44_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_subtractor44_seq
// Brief    : Self-checking bench for custom_subtractor44_seq with a queue
//            scoreboard of expected differences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_custom_subtractor44_seq;
   import sub44_pkg::*;

   localparam int N_CHUNKS = OPA_W / CHUNK_W_DEFAULT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [OPA_W-1:0] A;
   logic [OPB_W-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] Diff;
`ifdef SUB44_ZERO_FLAG_EN
   logic             Zero;
`endif

   always #5 clk = ~clk;

   custom_subtractor44_seq #(
      .CHUNK_W (CHUNK_W_DEFAULT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff)
`ifdef SUB44_ZERO_FLAG_EN
      ,
      .Zero      (Zero)
`endif
   );

   logic [RES_W-1:0] sb_q[$];
   int n_total = 0;
   int n_bad   = 0;
   int n_rcv   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [RES_W-1:0] model(input logic [OPA_W-1:0] a, input logic [OPB_W-1:0] b);
      return {1'b0, a} - {2'b00, b};
   endfunction

   // Output monitor: every transfer must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            logic [RES_W-1:0] exp;
            exp = sb_q.pop_front();
            check("diff", 64'(Diff), 64'(exp));
`ifdef SUB44_ZERO_FLAG_EN
            check("zero", 64'(Zero), 64'(exp == '0));
`endif
         end
         n_rcv++;
      end
   end

   task automatic send(input logic [OPA_W-1:0] a, input logic [OPB_W-1:0] b);
      int i;
      for (i = 0; i < 50 && !in_ready; i++) @(posedge clk) #1;
      check("send_timeout", 64'(in_ready), 64'd1);
      sb_q.push_back(model(a, b));
      in_valid = 1'b1;
      A = a;
      B = b;
      @(posedge clk) #1;
      in_valid = 1'b0;
      A = {$urandom(), $urandom()};
      B = {$urandom(), $urandom()};
   endtask

   task automatic wait_rcv(input int target);
      for (int i = 0; i < 60 && n_rcv < target; i++) @(posedge clk) #1;
      check("rcv_timeout", 64'(n_rcv >= target), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RES_W-1:0] hold;
      logic [63:0]      ra;
      logic [63:0]      rb;
      int k;
      int r0;

      rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;  A = '0;  B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(Diff), 64'd0);
`ifdef SUB44_ZERO_FLAG_EN
      check("rst_zero", 64'(Zero), 64'd1);
`endif
      rst_n = 1'b1;
      @(posedge clk) #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Basic case, also measuring accept-to-valid latency.
      send(44'd100, 43'd1);
      for (k = 1; k <= 20; k++) begin
         @(posedge clk) #1;
         if (out_valid) break;
      end
      check("latency", 64'(k), 64'(N_CHUNKS));
      wait_rcv(1);

      send(44'd0, 43'd1);                          // underflow
      wait_rcv(2);
      send(44'h800, 43'd1);                        // borrow crosses chunk 0 -> 1
      wait_rcv(3);
      send(44'hFFF_FFFF_FFFF, 43'h7FF_FFFF_FFFF);  // extremes
      wait_rcv(4);
      send(44'h7FF_FFFF_FFFF, 43'h7FF_FFFF_FFFF);  // equal operands
      wait_rcv(5);

      // Random operands issued back-to-back.
      for (int i = 0; i < 8; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         send(ra[OPA_W-1:0], rb[OPB_W-1:0]);
      end
      wait_rcv(13);

      // Backpressure: result held, new operands ignored.
      out_ready = 1'b0;
      send(44'h123_4567_89AB, 43'h0FE_DCBA_9876);
      for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk) #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      hold = Diff;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            A = 44'h000_0000_0AAA;
            B = 43'h000_0000_0555;
         end
         @(posedge clk) #1;
         in_valid = 1'b0;
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_diff", 64'(Diff), 64'(hold));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      r0 = n_rcv;
      out_ready = 1'b1;
      @(posedge clk) #1;
      check("bp_release_rcv", 64'(n_rcv), 64'(r0 + 1));
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      repeat (N_CHUNKS + 3) @(posedge clk);
      #1;
      check("bp_no_extra", 64'(n_rcv), 64'(r0 + 1));

      // Reset during the second BUSY cycle aborts the operation.
      in_valid = 1'b1;
      A = 44'hFFF_FFFF_FFFF;
      B = 43'd1;
      @(posedge clk) #1;
      in_valid = 1'b0;
      @(posedge clk) #1;
      check("mid_busy_diff_nz", 64'(Diff != '0), 64'd1);
      r0 = n_rcv;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_diff", 64'(Diff), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk) #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (N_CHUNKS + 3) @(posedge clk);
      #1;
      check("abort_no_stale", 64'(n_rcv), 64'(r0));
      check("abort_no_valid", 64'(out_valid), 64'd0);

      send(44'd5, 43'd5);
      wait_rcv(r0 + 1);

      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_custom_subtractor44_seq
`default_nettype wire
